dino_game_engine: RTL and testbench

//  Parametrised single-clock game engine and renderer for the 128x64 page-mode OLED.

---
 rtl/dino_game_if.sv | 24 ++
 rtl/dino_game_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dino_game_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dino_game_if.sv
// Engine-side bundle: frame/score strobes, player input, render byte bus and game status.
// Master drives the strobes, button, jumpOffset and pixelIndex; the engine (slave) returns the rest.
interface dino_game_if;
  logic        frame_tick;
  logic        score_tick;
  logic        button;
  logic        jumpOffset;
  logic [9:0]  pixelIndex;
  logic [7:0]  patternByte;
  logic        gameon;
  logic [1:0]  state;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;
  logic [2:0]  speed;

  modport master (
    output frame_tick, score_tick, button, jumpOffset, pixelIndex,
    input  patternByte, gameon, state, score_bcd, hi_bcd, speed
  );
  modport slave (
    input  frame_tick, score_tick, button, jumpOffset, pixelIndex,
    output patternByte, gameon, state, score_bcd, hi_bcd, speed
  );
endinterface

// File: rtl/dino_game_engine.sv
// Dino game engine: START/PLAY/OVER FSM, scrolling obstacles, BCD score and page-mode OLED renderer.
// Render latency 1 cycle; no backpressure, every strobe acts in the cycle it arrives.
module dino_game_engine #(
  parameter int              NUM_OBS        = 2,
  parameter int              SCREEN_W       = 128,
  parameter int              CAT_X          = 40,
  parameter int              CAT_W          = 16,
  parameter int              OBS_W          = 8,
  parameter int              SPEED_INIT     = 1,
  parameter int              SPEED_MAX      = 4,
  parameter int              MIN_GAP        = 48,
  parameter int              HOLDOFF_FRAMES = 16,
  parameter logic [15:0]     LFSR_SEED      = 16'hACE1
) (
  input  logic     CLK_27MHZ,
  input  logic     rst_n,
  dino_game_if.slave io
);

  typedef enum logic [1:0] {ST_START = 2'b00, ST_PLAY = 2'b01, ST_OVER = 2'b10} state_e;

  localparam logic [7:0] SPAWN_RE = 8'(SCREEN_W + OBS_W);
  localparam logic [7:0] OBS_W8   = 8'(OBS_W);
  localparam logic [7:0] CAT_L    = 8'(CAT_X);
  localparam logic [7:0] CAT_R    = 8'(CAT_X + CAT_W);
  localparam logic [7:0] COL_LO   = 8'(CAT_X + 1);
  localparam logic [7:0] COL_HI   = 8'(CAT_X + CAT_W + OBS_W - 1);
  localparam logic [7:0] GAP8     = 8'(MIN_GAP);
  localparam logic [7:0] HOLD8    = 8'(HOLDOFF_FRAMES);
  localparam logic [2:0] SPD_INIT = 3'(SPEED_INIT);
  localparam logic [2:0] SPD_MAX  = 3'(SPEED_MAX);
  localparam logic [127:0] CAT_TOP = 128'h0000_C0E0_F0F8_F8F0_C0C0_C0E0_F8FC_7C18;
  localparam logic [127:0] CAT_BOT = 128'h0000_070F_FFFF_FF0F_0F0F_0FFF_FFFF_0F03;

  state_e               state_q, state_d;
  logic [15:0]          score_q, score_d, hi_q, hi_d, lfsr_q, lfsr_d;
  logic [2:0]           speed_q, speed_d;
  logic [7:0]           spawn_cnt_q, spawn_cnt_d, hold_cnt_q, hold_cnt_d, pat_q, pat_d;
  logic                 prev_btn_q, prev_btn_d;
  logic [NUM_OBS-1:0]   act_q, act_d;
  logic [7:0]           re_q [NUM_OBS];
  logic [7:0]           re_d [NUM_OBS];
  logic                 btn_edge, collide, spawned, obs_hit;
  logic [2:0]           page, cat_pg;
  logic [7:0]           col8;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
        else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 5x7 font, column-major, LSB at top; codes 0-9 digits, 10-14 "SCORE", 15 colon.
  function automatic logic [7:0] glyph(input logic [3:0] code, input logic [2:0] sub);
    logic [39:0] g;
    case (code)
      4'd0:    g = 40'h3E5149453E;
      4'd1:    g = 40'h00427F4000;
      4'd2:    g = 40'h4261514946;
      4'd3:    g = 40'h2141454B31;
      4'd4:    g = 40'h1814127F10;
      4'd5:    g = 40'h2745454539;
      4'd6:    g = 40'h3C4A494930;
      4'd7:    g = 40'h0171090503;
      4'd8:    g = 40'h3649494936;
      4'd9:    g = 40'h064949291E;
      4'd10:   g = 40'h4649494931;
      4'd11:   g = 40'h3E41414122;
      4'd12:   g = 40'h3E4141413E;
      4'd13:   g = 40'h7F09192946;
      4'd14:   g = 40'h7F49494941;
      default: g = 40'h0036360000;
    endcase
    case (sub)
      3'd0:    return g[39:32];
      3'd1:    return g[31:24];
      3'd2:    return g[23:16];
      3'd3:    return g[15:8];
      3'd4:    return g[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] label_byte(input logic [7:0] off);
    logic [3:0] code;
    case (off / 8'd6)
      8'd0:    code = 4'd10;
      8'd1:    code = 4'd11;
      8'd2:    code = 4'd12;
      8'd3:    code = 4'd13;
      8'd4:    code = 4'd14;
      default: code = 4'd15;
    endcase
    return glyph(code, 3'(off % 8'd6));
  endfunction

  // off counts from the first digit column; 8 columns per digit, MSD first.
  function automatic logic [7:0] digit_byte(input logic [15:0] v, input logic [7:0] off);
    logic [3:0] d;
    case (off / 8'd8)
      8'd0:    d = v[15:12];
      8'd1:    d = v[11:8];
      8'd2:    d = v[7:4];
      default: d = v[3:0];
    endcase
    return glyph(d, 3'(off));
  endfunction

  function automatic logic [7:0] image_byte(input logic [2:0] pg, input logic [7:0] c);
    if (c == 8'd0 || c == 8'(SCREEN_W - 1)) return 8'hFF;
    if (pg == 3'd0) return 8'h01;
    if (pg == 3'd7) return 8'h80;
    if (pg == 3'd3 && c >= 8'd32 && c < 8'd96) return c[2] ? 8'h3C : 8'h18;
    return 8'h00;
  endfunction

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_OBS; i++)
      if (act_q[i] && re_q[i] >= COL_LO && re_q[i] <= COL_HI) collide = 1'b1;
    if (io.jumpOffset) collide = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hi_d        = hi_q;
    speed_d     = speed_q;
    spawn_cnt_d = spawn_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    prev_btn_d  = prev_btn_q;
    act_d       = act_q;
    re_d        = re_q;
    spawned     = 1'b0;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    btn_edge    = prev_btn_q & ~io.button;

    if (io.score_tick && state_q == ST_PLAY && score_q != 16'h9999) begin
      score_d = bcd_inc(score_q);
      if (score_d[7:0] == 8'h00 && speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
    end

    if (io.frame_tick) begin
      prev_btn_d = io.button;
      case (state_q)
        ST_START: begin
          if (btn_edge) begin
            state_d     = ST_PLAY;
            score_d     = '0;
            speed_d     = SPD_INIT;
            act_d       = '0;
            spawn_cnt_d = GAP8;
          end
        end
        ST_PLAY: begin
          if (collide) begin
            state_d    = ST_OVER;
            hold_cnt_d = HOLD8;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            for (int i = 0; i < NUM_OBS; i++) begin
              if (act_q[i]) begin
                if (re_q[i] <= {5'b0, speed_q}) act_d[i] = 1'b0;
                else re_d[i] = re_q[i] - {5'b0, speed_q};
              end
            end
            if (spawn_cnt_q != 8'd0) spawn_cnt_d = spawn_cnt_q - 8'd1;
            else begin
              // A slot vacated this same tick is already eligible.
              for (int i = 0; i < NUM_OBS; i++) begin
                if (!spawned && !act_d[i]) begin
                  spawned  = 1'b1;
                  act_d[i] = 1'b1;
                  re_d[i]  = SPAWN_RE;
                end
              end
              if (spawned) spawn_cnt_d = GAP8 + {2'b00, lfsr_q[5:0]};
            end
          end
        end
        ST_OVER: begin
          if (hold_cnt_q != 8'd0) hold_cnt_d = hold_cnt_q - 8'd1;
          else if (btn_edge) state_d = ST_START;
        end
        default: state_d = ST_START;
      endcase
    end
  end

  assign page   = io.pixelIndex[9:7];
  assign col8   = {1'b0, io.pixelIndex[6:0]};
  assign cat_pg = io.jumpOffset ? 3'd1 : 3'd4;

  always_comb begin
    obs_hit = 1'b0;
    for (int i = 0; i < NUM_OBS; i++)
      if (act_q[i] && (col8 + OBS_W8 >= re_q[i]) && (col8 < re_q[i])) obs_hit = 1'b1;
  end

  always_comb begin
    pat_d = 8'h00;
    if (state_q != ST_PLAY) begin
      pat_d = image_byte(page, col8);
      if (state_q == ST_OVER && page == 3'd0 && col8 >= 8'd85 && col8 <= 8'd116)
        pat_d = pat_d | digit_byte(hi_q, col8 - 8'd85);
    end else if (page == 3'd6) begin
      pat_d = 8'hF0;
    end else if (page == 3'd0) begin
      if (col8 >= 8'd49 && col8 <= 8'd82) pat_d = label_byte(col8 - 8'd49);
      else if (col8 >= 8'd85 && col8 <= 8'd116) pat_d = digit_byte(score_q, col8 - 8'd85);
    end else if ((page == cat_pg || page == cat_pg + 3'd1) && col8 >= CAT_L && col8 < CAT_R) begin
      pat_d = 8'((page == cat_pg ? CAT_TOP : CAT_BOT) >> {4'd15 - 4'(col8 - CAT_L), 3'b000});
    end else if (page == 3'd5 && obs_hit) begin
      pat_d = 8'hFF;
    end
  end

  always_ff @(posedge CLK_27MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      score_q     <= '0;
      hi_q        <= '0;
      speed_q     <= SPD_INIT;
      spawn_cnt_q <= '0;
      hold_cnt_q  <= '0;
      prev_btn_q  <= 1'b1;
      lfsr_q      <= LFSR_SEED;
      pat_q       <= '0;
      act_q       <= '0;
      for (int i = 0; i < NUM_OBS; i++) re_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      speed_q     <= speed_d;
      spawn_cnt_q <= spawn_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      prev_btn_q  <= prev_btn_d;
      lfsr_q      <= lfsr_d;
      pat_q       <= pat_d;
      act_q       <= act_d;
      for (int i = 0; i < NUM_OBS; i++) re_q[i] <= re_d[i];
    end
  end

  assign io.patternByte = pat_q;
  assign io.gameon      = (state_q == ST_PLAY);
  assign io.state       = state_q;
  assign io.score_bcd   = score_q;
  assign io.hi_bcd      = hi_q;
  assign io.speed       = speed_q;

endmodule

// File: tb/tb_dino_game_engine.sv
// Directed bench for dino_game_engine: reset, start, scroll/render, score ramp, collision, holdoff.
// Inputs change and outputs are sampled 1 time unit after the rising clock edge.
module tb_dino_game_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dino_game_if io();

  dino_game_engine u_dut (
    .CLK_27MHZ (clk),
    .rst_n     (rst_n),
    .io        (io)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_frame();
    io.frame_tick = 1'b1;
    @(posedge clk); #1;
    io.frame_tick = 1'b0;
  endtask

  task automatic tick_score();
    io.score_tick = 1'b1;
    @(posedge clk); #1;
    io.score_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) tick_frame();
  endtask

  task automatic scores(input int n);
    for (int k = 0; k < n; k++) tick_score();
  endtask

  task automatic render(input logic [9:0] idx, input logic [7:0] exp, input string tag);
    io.pixelIndex = idx;
    @(posedge clk); #1;
    check_eq(tag, 32'(io.patternByte), 32'(exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    io.frame_tick = 1'b0;
    io.score_tick = 1'b0;
    io.button     = 1'b1;
    io.jumpOffset = 1'b0;
    io.pixelIndex = 10'd0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(io.state), 32'd0);
    check_eq("rst_pattern", 32'(io.patternByte), 32'd0);
    check_eq("rst_hi", 32'(io.hi_bcd), 32'd0);
    check_eq("rst_speed", 32'(io.speed), 32'd1);
    check_eq("rst_gameon", 32'(io.gameon), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start
    io.button = 1'b0;
    tick_frame();
    check_eq("start_state", 32'(io.state), 32'd1);
    check_eq("start_gameon", 32'(io.gameon), 32'd1);
    check_eq("start_spawn_cnt", 32'(u_dut.spawn_cnt_q), 32'd48);
    scores(12);
    check_eq("score_12", 32'(io.score_bcd), 32'h0012);
    io.button = 1'b1;
    tick_frame();
    check_eq("first_play_spawn_cnt", 32'(u_dut.spawn_cnt_q), 32'd47);
    frames(47);
    check_eq("spawn_cnt_zero", 32'(u_dut.spawn_cnt_q), 32'd0);
    check_eq("no_obs_yet", 32'(u_dut.act_q), 32'd0);
    tick_frame();
    check_eq("spawn_slot0", 32'(u_dut.act_q), 32'b01);
    check_eq("spawn_re", 32'(u_dut.re_q[0]), 32'd136);

    // scroll and render
    io.jumpOffset = 1'b1;
    frames(9);
    check_eq("scroll_re", 32'(u_dut.re_q[0]), 32'd127);
    render(10'd760, 8'hFF, "obs_col120");
    render(10'd758, 8'h00, "obs_col118");
    render(10'd771, 8'hF0, "ground_page6");
    render(10'd85, 8'h3E, "score_digit0");
    render(10'd109, 8'h42, "score_digit3");

    // collision while airborne is ignored, then on the ground it ends the game
    frames(77);
    check_eq("pre_collide_re", 32'(u_dut.re_q[0]), 32'd50);
    check_eq("jump_stays_play", 32'(io.state), 32'd1);
    io.jumpOffset = 1'b0;
    tick_frame();
    check_eq("collide_over", 32'(io.state), 32'd2);
    check_eq("collide_hi", 32'(io.hi_bcd), 32'h0012);
    check_eq("collide_frozen_re", 32'(u_dut.re_q[0]), 32'd50);
    render(10'd109, 8'h43, "over_hi_digit3");

    // holdoff
    frames(2);
    io.button = 1'b0;
    tick_frame();
    check_eq("holdoff_press3", 32'(io.state), 32'd2);
    frames(6);
    io.button = 1'b1;
    frames(7);
    check_eq("holdoff_frame16", 32'(io.state), 32'd2);
    io.button = 1'b0;
    tick_frame();
    check_eq("holdoff_frame17", 32'(io.state), 32'd0);

    // new game, score ramp and saturation
    io.button = 1'b1;
    tick_frame();
    io.button = 1'b0;
    io.jumpOffset = 1'b1;
    tick_frame();
    check_eq("restart_state", 32'(io.state), 32'd1);
    check_eq("restart_score", 32'(io.score_bcd), 32'd0);
    scores(99);
    check_eq("score_0099", 32'(io.score_bcd), 32'h0099);
    check_eq("speed_at_99", 32'(io.speed), 32'd1);
    tick_score();
    check_eq("score_0100", 32'(io.score_bcd), 32'h0100);
    check_eq("speed_at_100", 32'(io.speed), 32'd2);
    scores(9899);
    check_eq("score_9999", 32'(io.score_bcd), 32'h9999);
    check_eq("speed_capped", 32'(io.speed), 32'd4);
    tick_score();
    check_eq("score_saturates", 32'(io.score_bcd), 32'h9999);

    // reset mid-game loses the high score
    rst_n = 1'b0;
    #2;
    check_eq("midrst_state", 32'(io.state), 32'd0);
    check_eq("midrst_hi", 32'(io.hi_bcd), 32'd0);
    check_eq("midrst_speed", 32'(io.speed), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
